// File: rtl/pong_pkg.sv
// Shared definitions for the Pong display path: seven-segment patterns,
// the blank pattern and the scan digit-index encoding.
package pong_pkg;

   // Active-low segment patterns for digits 0..9, bit0=a .. bit6=g
   localparam logic [6:0] SEG_PAT [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   // All segments off
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Scan order: left to right across the four digits
   typedef enum logic [1:0] {
      IDX_P1_TENS = 2'd0,
      IDX_P1_ONES = 2'd1,
      IDX_P2_TENS = 2'd2,
      IDX_P2_ONES = 2'd3
   } digit_idx_e;

   // Segment pattern for a decimal digit; out-of-range values show blank
   function automatic logic [6:0] seg_digit(input logic [3:0] d, input logic blank);
      logic [6:0] r;
      if (blank) begin
         r = SEG_BLANK;
      end else if (d > 4'd9) begin
         r = SEG_BLANK;
      end else begin
         r = SEG_PAT[d];
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd5.sv
// Combinational 5-bit binary to two-digit BCD split (0..31 -> tens 0..3, ones 0..9).
module bin2bcd5 (
   input  logic [4:0] bin,
   output logic [1:0] tens,
   output logic [3:0] ones
);

   assign tens = 2'(bin / 5'd10);
   assign ones = 4'(bin % 5'd10);

endmodule

// File: rtl/score_display.sv
// Four-digit multiplexed seven-segment scoreboard for two player scores.
// Scores are snapshotted once per scan frame so digits never tear, each digit
// period starts with an all-anodes-off guard, and all outputs are registered.
// Optional feature: define SCORE_BLINK_EN to blink the leader's digits while
// game_over is high.
module score_display #(
   parameter int DIGIT_PERIOD = 100000,
   parameter int GUARD        = 16,
   parameter int BLINK_PERIOD = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] score1,
   input  logic [4:0] score2,
   input  logic       game_over,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);
   import pong_pkg::*;

   localparam int CW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_PERIOD - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] GUARD_END = CW'(GUARD);

   logic [CW-1:0] cnt_q, cnt_d;
   digit_idx_e    idx_q, idx_d;
   logic [4:0]    s1_q, s1_d;
   logic [4:0]    s2_q, s2_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic [1:0] p1_tens, p2_tens;
   logic [3:0] p1_ones, p2_ones;
   logic       hide_p1, hide_p2;

   bin2bcd5 u_bcd_p1 (.bin(s1_q), .tens(p1_tens), .ones(p1_ones));
   bin2bcd5 u_bcd_p2 (.bin(s2_q), .tens(p2_tens), .ones(p2_ones));

   // Refresh counter, digit index and frame-boundary score snapshot
   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      s1_d  = s1_q;
      s2_d  = s2_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = digit_idx_e'(idx_q + 2'd1);
         if (idx_q == IDX_P2_ONES) begin
            s1_d = score1;
            s2_d = score2;
         end else begin
            s1_d = s1_q;
            s2_d = s2_q;
         end
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

`ifdef SCORE_BLINK_EN
   localparam int BW = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;
   localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_PERIOD - 1);
   localparam logic [BW-1:0] BLK_HALF = BW'(BLINK_PERIOD / 2);
   localparam logic [BW-1:0] BLK_ONE  = BW'(1);

   logic [BW-1:0] blk_q, blk_d;
   logic          go_q, go_d;
   logic          blink_off;

   // Blink counter restarts on the rising edge of game_over, else free-runs
   always_comb begin
      go_d = game_over;
      if (game_over && !go_q) begin
         blk_d = '0;
      end else if (blk_q == BLK_LAST) begin
         blk_d = '0;
      end else begin
         blk_d = blk_q + BLK_ONE;
      end
   end

   assign blink_off = (blk_q >= BLK_HALF);
   // Leader is whoever is ahead; a tie hides both players
   assign hide_p1   = game_over & blink_off & (s1_q >= s2_q);
   assign hide_p2   = game_over & blink_off & (s2_q >= s1_q);

   // Blink phase state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blk_q <= '0;
         go_q  <= 1'b0;
      end else begin
         blk_q <= blk_d;
         go_q  <= go_d;
      end
   end
`else
   logic unused_game_over;
   assign unused_game_over = game_over;
   assign hide_p1 = 1'b0;
   assign hide_p2 = 1'b0;
`endif

   // Output decode: digit select, blanking of leading zero, guard and blink masks
   always_comb begin
      an_d  = 4'b1111;
      seg_d = SEG_BLANK;
      case (idx_q)
         IDX_P1_TENS: begin
            an_d  = 4'b0111;
            seg_d = seg_digit({2'b00, p1_tens}, p1_tens == 2'd0);
         end
         IDX_P1_ONES: begin
            an_d  = 4'b1011;
            seg_d = seg_digit(p1_ones, 1'b0);
         end
         IDX_P2_TENS: begin
            an_d  = 4'b1101;
            seg_d = seg_digit({2'b00, p2_tens}, p2_tens == 2'd0);
         end
         IDX_P2_ONES: begin
            an_d  = 4'b1110;
            seg_d = seg_digit(p2_ones, 1'b0);
         end
         default: begin
            an_d  = 4'b1111;
            seg_d = SEG_BLANK;
         end
      endcase
      if (cnt_q < GUARD_END) begin
         an_d = 4'b1111;
      end else begin
         an_d = an_d | {hide_p1, hide_p1, hide_p2, hide_p2};
      end
      dp_d = ~((idx_q == IDX_P1_ONES) & ~an_d[2]);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         idx_q <= IDX_P1_TENS;
         s1_q  <= 5'd0;
         s2_q  <= 5'd0;
         an_q  <= 4'b1111;
         seg_q <= SEG_BLANK;
         dp_q  <= 1'b1;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display with DIGIT_PERIOD=8, GUARD=2, BLINK_PERIOD=64.
// A reference model predicts each registered output on every clock and queues it;
// the queue is compared against the DUT half a cycle later. Directed checks add
// spec-derived constants for the key display cases.
module tb_score_display;

   localparam int DP_T = 8;
   localparam int GD_T = 2;
   localparam int BP_T = 64;

   localparam logic [6:0] PAT [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } out_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] score1, score2;
   logic       game_over;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int   checks = 0;
   int   errors = 0;
   out_t exp_q[$];
   out_t exp_e;

   int m_cnt, m_idx, m_s1, m_s2, m_blk;
   bit m_go;

   score_display #(.DIGIT_PERIOD(DP_T), .GUARD(GD_T), .BLINK_PERIOD(BP_T)) dut (
      .clk(clk), .rst(rst), .score1(score1), .score2(score2),
      .game_over(game_over), .an(an), .seg(seg), .dp(dp)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Expected registered output for a given model state
   function automatic out_t model_out(int cnt, int idx, int s1, int s2, bit off, bit go);
      out_t o;
      int sv, tens, ones;
      sv   = (idx < 2) ? s1 : s2;
      tens = sv / 10;
      ones = sv % 10;
      if (idx == 0 || idx == 2) o.seg = (tens == 0) ? 7'h7F : PAT[tens];
      else                      o.seg = PAT[ones];
      o.an = 4'b1111;
      if (cnt >= GD_T) begin
         o.an = ~(4'b1000 >> idx);
`ifdef SCORE_BLINK_EN
         if (go && off) begin
            if (s1 >= s2) o.an[3:2] = 2'b11;
            if (s2 >= s1) o.an[1:0] = 2'b11;
         end
`endif
      end
      o.dp = !(idx == 1 && o.an[2] == 1'b0);
      return o;
   endfunction

   // Reference model: queue the output for this edge, then advance state
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cnt <= 0; m_idx <= 0; m_s1 <= 0; m_s2 <= 0; m_blk <= 0; m_go <= 1'b0;
      end else begin
         exp_q.push_back(model_out(m_cnt, m_idx, m_s1, m_s2, m_blk >= BP_T / 2, game_over));
         if (m_cnt == DP_T - 1) begin
            m_cnt <= 0;
            m_idx <= (m_idx + 1) % 4;
            if (m_idx == 3) begin
               m_s1 <= int'(score1);
               m_s2 <= int'(score2);
            end
         end else begin
            m_cnt <= m_cnt + 1;
         end
         if (game_over && !m_go) m_blk <= 0;
         else                    m_blk <= (m_blk + 1) % BP_T;
         m_go <= game_over;
      end
   end

   // Scoreboard compare on the falling edge
   always @(negedge clk) begin
      if (rst && exp_q.size() != 0) begin
         exp_e = exp_q.pop_front();
         check_eq("scan", {20'd0, an, seg, dp}, {20'd0, exp_e});
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_an(input logic [3:0] pat, input logic [6:0] es, input logic ed, input string tag);
      int n = 0;
      while (an !== pat && n < 40) begin
         step();
         n++;
      end
      check_eq({tag, "_an"}, {28'd0, an}, {28'd0, pat});
      check_eq({tag, "_seg"}, {25'd0, seg}, {25'd0, es});
      check_eq({tag, "_dp"}, {31'd0, dp}, {31'd0, ed});
   endtask

   task automatic check_first_on(input string tag);
      int first = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         if (an !== 4'hF && first == 0) first = k;
      end
      check_eq(tag, first, GD_T + 1);
   endtask

   task automatic check_guard();
      int n;
      logic [3:0] p;
      n = 0;
      while (an === 4'hF && n < 20) begin step(); n++; end
      n = 0;
      while (an !== 4'hF && n < 20) begin step(); n++; end
      for (int d = 0; d < 4; d++) begin
         n = 0;
         while (an === 4'hF && n < 20) begin step(); n++; end
         check_eq("guard_len", n, GD_T);
         check_eq("onehot", $countones(~an), 1);
         p = an;
         n = 0;
         while (an === p && n < 20) begin step(); n++; end
         check_eq("active_len", n, DP_T - GD_T);
      end
   endtask

   initial begin
      rst = 1'b0; score1 = 5'd0; score2 = 5'd0; game_over = 1'b0;
      #12;
      check_eq("rst_an", {28'd0, an}, 32'hF);
      check_eq("rst_seg", {25'd0, seg}, 32'h7F);
      check_eq("rst_dp", {31'd0, dp}, 32'h1);
      @(negedge clk);
      rst = 1'b1;
      check_first_on("first_on");

      // Static scores 17 / 5
      step();
      score1 = 5'd17; score2 = 5'd5;
      repeat (70) step();
      wait_an(4'b0111, 7'h79, 1'b1, "s17_t");
      wait_an(4'b1011, 7'h78, 1'b0, "s17_o");
      wait_an(4'b1101, 7'h7F, 1'b1, "s5_t");
      wait_an(4'b1110, 7'h12, 1'b1, "s5_o");

      // Reset mid-scan while P1 ones is lit
      wait_an(4'b1011, 7'h78, 1'b0, "pre_rst");
      #2;
      rst = 1'b0;
      #1;
      exp_q.delete();
      check_eq("mid_rst_an", {28'd0, an}, 32'hF);
      check_eq("mid_rst_seg", {25'd0, seg}, 32'h7F);
      check_eq("mid_rst_dp", {31'd0, dp}, 32'h1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      check_first_on("first_on2");

      // Maximum value 31 / 0
      step();
      score1 = 5'd31; score2 = 5'd0;
      repeat (70) step();
      wait_an(4'b0111, 7'h30, 1'b1, "max_t");
      wait_an(4'b1011, 7'h79, 1'b0, "max_o");
      wait_an(4'b1101, 7'h7F, 1'b1, "zero_t");
      wait_an(4'b1110, 7'h40, 1'b1, "zero_o");

      // Tearing: score2 changes mid-frame
      score1 = 5'd4; score2 = 5'd9;
      repeat (70) step();
      wait_an(4'b1011, 7'h19, 1'b0, "tear_p1");
      score2 = 5'd10;
      wait_an(4'b1101, 7'h7F, 1'b1, "tear_old_t");
      wait_an(4'b1110, 7'h10, 1'b1, "tear_old_o");
      wait_an(4'b1101, 7'h79, 1'b1, "tear_new_t");
      wait_an(4'b1110, 7'h40, 1'b1, "tear_new_o");

      // Guard timing
      check_guard();

      // Game over with a leader, then a tie
      score1 = 5'd3; score2 = 5'd1;
      repeat (40) step();
      game_over = 1'b1;
      repeat (140) step();
      game_over = 1'b0;
      score1 = 5'd2; score2 = 5'd2;
      repeat (40) step();
      game_over = 1'b1;
      repeat (140) step();
      game_over = 1'b0;
      repeat (10) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/score_display.md
# score_display

Seven-segment scoreboard driver for the Pong game. It consumes the two player scores from `game_controller` and drives a common-anode 4-digit multiplexed display: player 1 on the left pair of digits, player 2 on the right pair. The block snapshots the scores once per scan frame so a digit never shows a torn value. It inserts a ghosting guard between digits and, when configured, blinks the leader's digits after the game ends.

## Interface
Parameters:
- `DIGIT_PERIOD`, default 100000: clk cycles each digit is selected (1 ms at 100 MHz); minimum `GUARD`+2.
- `GUARD`, default 16: cycles at the start of each digit period with all anodes off.
- `BLINK_PERIOD`, default 25000000: full blink cycle in clk cycles; even; used only with blink enabled.

Ports:
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: reset, asynchronous, active-low.
- `score1` in 5: player 1 score, 0..31.
- `score2` in 5: player 2 score, 0..31.
- `game_over` in 1: level, high while the match is finished.
- `an` out 4: digit anodes, active-low; `an[3]` is P1 tens, `an[2]` P1 ones, `an[1]` P2 tens, `an[0]` P2 ones.
- `seg` out 7: segments, active-low; bit0=a … bit6=g.
- `dp` out 1: decimal point, active-low; used as the score separator.

## Operation
- Refresh counter `cnt` runs 0..`DIGIT_PERIOD`-1 and wraps. On wrap, the digit index `idx` (2 bits) increments mod 4.
- `idx` 0,1,2,3 selects `an[3]`,`an[2]`,`an[1]`,`an[0]` respectively.
- Snapshot registers `s1`,`s2` load `score1`,`score2` on the cycle `cnt` wraps while `idx`==3, which is the frame boundary. Score changes at any other time stay invisible until the next frame.
- Digit value: tens = s/10 (0..3), ones = s%10. The arithmetic is 5-bit and unsigned.
- A tens digit equal to 0 is blanked: `seg`=7'h7F, but its anode is still driven.
- Patterns for 0..9: 40,79,24,30,19,12,02,78,00,10 (hex).
- `dp` is 0 only while `idx`==1 (P1 ones) and the anode is on; otherwise it is 1.
- Guard: while `cnt` < `GUARD`, `an`=4'b1111. `seg` and `dp` already carry the new digit during the guard.
- All outputs are registered, so the pipeline is index/count → output with 1 cycle of latency.

## Timing
- Reset, asynchronous: `an`=4'b1111, `seg`=7'h7F, `dp`=1, `cnt`=0, `idx`=0, `s1`=`s2`=0, blink phase=0.
- The first anode turns on at cycle `GUARD`+1 after `rst` deasserts. The display reads "blank 0 | blank 0" until the first frame boundary, 4×`DIGIT_PERIOD` cycles after reset.
- A reset asserted mid-scan forces the reset values in the same cycle, with no clock required.
- A score input change is shown within at most 4×`DIGIT_PERIOD`+1 cycles.
- Frame period is exactly 4×`DIGIT_PERIOD` cycles.
- No handshake exists. The score inputs are assumed stable for ≥1 cycle, since they come from the same clk domain.

## Configuration
- `SCORE_BLINK_EN` defined:
  - A blink counter runs 0..`BLINK_PERIOD`-1; the phase is "off" during the second half of the count.
  - While `game_over`=1 and the phase is off, the leader's two anodes are forced high. The leader is P1 if `s1`>`s2`, P2 if `s2`>`s1`, and both players on a tie.
  - The blink counter resets to 0 on the rising edge of `game_over`.
- `SCORE_BLINK_EN` undefined:
  - No blink counter is built.
  - `game_over` is ignored but the port remains.

## Structure
- Shared package `pong_pkg` holds:
  - the 7-segment pattern constant array (10 entries);
  - the blank pattern 7'h7F;
  - the digit-index encoding.
- One sub-module, `bin2bcd5`, converts a 5-bit binary value to tens (2-bit) and ones (4-bit). It is combinational and instantiated once per score.

## Test plan
Use `DIGIT_PERIOD`=8, `GUARD`=2, `BLINK_PERIOD`=64.
- Reset: pulse `rst` low mid-scan → `an`=1111, `seg`=7F, `dp`=1 immediately, and the first anode goes low 3 cycles after release.
- Static scores: `score1`=17, `score2`=5 → after the next frame boundary:
  - `an`=0111 shows `seg`=79;
  - `an`=1011 shows `seg`=78 with `dp`=0;
  - `an`=1101 shows `seg`=7F;
  - `an`=1110 shows `seg`=12.
- Maximum value: `score1`=31, `score2`=0 → `seg`=30 and 79 on the P1 digits, 7F and 40 on the P2 digits.
- Tearing: change `score2` from 9 to 10 while `idx`=1 → the P2 digits still show blank/9 in that frame, and 1/0 (`seg`=79, 40) only in the following frame.
- Guard: on every `idx` transition, `an`=1111 for exactly 2 cycles, then the one-hot-low anode is held for 6 cycles.
- Blink (`SCORE_BLINK_EN`): `score1`=3, `score2`=1, `game_over`=1 → `an[3]`/`an[2]` stay high for cycles 32..63 of each blink period, while the P2 digits are unaffected. With a tie at 2–2, all four anodes blank in the off phase.
